// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared pipeline definitions for the memory-access stage:
//   - load_mode encoding (also used as the store size encoding)
//   - wait-state FSM state encoding
//   - helpers that build the store byte enables and lane data
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    // Access size / extension encoding carried on in_load_mode.
    localparam logic [1:0] LM_WORD   = 2'b00;
    localparam logic [1:0] LM_HALF_S = 2'b01;
    localparam logic [1:0] LM_BYTE_S = 2'b10;
    localparam logic [1:0] LM_BYTE_U = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    // Byte enables for a store of the given size at byte offset lane.
    function automatic logic [3:0] store_be(input logic [1:0] mode,
                                            input logic [1:0] lane);
        logic [3:0] be;
        case (mode)
            LM_WORD:   be = 4'b1111;
            LM_HALF_S: be = lane[1] ? 4'b1100 : 4'b0011;
            default:   be = 4'b0001 << lane;
        endcase
        return be;
    endfunction

    // Store data replicated into every lane; byte enables pick the real one.
    function automatic logic [31:0] store_data(input logic [1:0]  mode,
                                               input logic [31:0] rt);
        logic [31:0] d;
        case (mode)
            LM_WORD:   d = rt;
            LM_HALF_S: d = {2{rt[15:0]}};
            default:   d = {4{rt[7:0]}};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
// Word-organised data RAM with a byte-enable synchronous write port and an
// asynchronous read port sharing one word index. Contents are not reset.
// Ports:
//   clk    in   write clock
//   we     in   write strobe (commits on rising edge)
//   be     in   [3:0] byte enables, bit i covers data[8i+7:8i]
//   idx    in   [AW-1:0] word index for both read and write
//   wdata  in   [31:0] write data (lane-aligned)
//   rdata  out  [31:0] combinational read of word idx
// -----------------------------------------------------------------------------
module data_memory #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access stage of the 5-stage MIPS pipeline: owns the data memory,
// performs word/half/byte loads and stores, optionally stretches each access
// with wait states (stalling upstream), and ends in the MEM/WB register.
//
// Parameters:
//   DEPTH        data memory words (power of two)
//   WAIT_CYCLES  stall cycles per memory access (0..15)
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   in_RegWrite/MemWrite/MemRead/MemToReg  EX/MEM control bits
//   in_load_mode [1:0]               00 word, 01 half s, 10 byte s, 11 byte u
//   in_zero, in_pc [31:0]            forwarded combinationally to fetch
//   in_aluResult [31:0]              byte address / ALU result
//   in_rt [31:0]                     store data
//   in_writebackDestination [4:0]    destination register
//   stall                            combinational, hold EX/MEM while high
//   zero_fwd, pc_fwd                 passthrough of in_zero / in_pc
//   RegWrite_out, MemToReg_out, readData_out, aluResult_out,
//   writebackDestination_out         MEM/WB register outputs
//   misalign_out                     only with MEM_STAGE_MISALIGN_TRAP_EN
//
// Build option: define MEM_STAGE_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (write suppressed, RegWrite forced low, misalign_out flagged).
// Without it, low address bits below the access size are ignored.
// -----------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_RegWrite,
    input  logic        in_MemWrite,
    input  logic        in_MemRead,
    input  logic        in_MemToReg,
    input  logic [1:0]  in_load_mode,
    input  logic        in_zero,
    input  logic [31:0] in_aluResult,
    input  logic [31:0] in_rt,
    input  logic [4:0]  in_writebackDestination,
    input  logic [31:0] in_pc,
    output logic        stall,
    output logic        zero_fwd,
    output logic [31:0] pc_fwd,
    output logic        RegWrite_out,
    output logic        MemToReg_out,
    output logic [31:0] readData_out,
    output logic [31:0] aluResult_out,
    output logic [4:0]  writebackDestination_out
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    ,
    output logic        misalign_out
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    assign zero_fwd = in_zero;
    assign pc_fwd   = in_pc;

    logic access;
    assign access = in_MemRead | in_MemWrite;

    // Address bits above the memory size are ignored so addresses wrap.
    logic          unused_addr_hi;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    assign idx            = in_aluResult[AW+1:2];
    assign lane           = in_aluResult[1:0];
    assign unused_addr_hi = ^in_aluResult[31:AW+2];

    // ------------------------------------------------------------------
    // Misalignment detection
    // ------------------------------------------------------------------
    logic misalign;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign misalign = access &&
                      (((in_load_mode == LM_WORD)   && (lane != 2'b00)) ||
                       ((in_load_mode == LM_HALF_S) && lane[0]));
`else
    assign misalign = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Wait-state FSM
    // ------------------------------------------------------------------
    mem_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       stall_raw;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access && (WAIT_CYCLES > 0)) begin
                    stall_raw = 1'b1;
                    cnt_d     = WAIT_INIT;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    stall_raw = 1'b1;
                    cnt_d     = cnt_q - 4'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset must drop stall at once even if upstream still presents an access.
    assign stall = stall_raw & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Data memory: write commits only on the completing cycle.
    // ------------------------------------------------------------------
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    assign mem_we    = in_MemWrite & ~stall & ~misalign & ~rst;
    assign mem_be    = store_be(in_load_mode, lane);
    assign mem_wdata = store_data(in_load_mode, in_rt);

    data_memory #(.DEPTH(DEPTH)) u_dmem (
        .clk   (clk),
        .we    (mem_we),
        .be    (mem_be),
        .idx   (idx),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // ------------------------------------------------------------------
    // Load formatting
    // ------------------------------------------------------------------
    logic [31:0] load_data;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        half_sel = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        byte_sel = mem_rdata[8*lane +: 8];
        case (in_load_mode)
            LM_WORD:   load_data = mem_rdata;
            LM_HALF_S: load_data = {{16{half_sel[15]}}, half_sel};
            LM_BYTE_S: load_data = {{24{byte_sel[7]}}, byte_sel};
            default:   load_data = {24'd0, byte_sel};
        endcase
        if (!in_MemRead) load_data = 32'd0;
    end

    // ------------------------------------------------------------------
    // MEM/WB register: a stall inserts a bubble, data fields hold.
    // ------------------------------------------------------------------
    logic        reg_write_q, reg_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic [31:0] read_data_q, read_data_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [4:0]  wb_dest_q, wb_dest_d;
    logic        misalign_q, misalign_d;

    always_comb begin
        reg_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        read_data_d  = read_data_q;
        alu_result_d = alu_result_q;
        wb_dest_d    = wb_dest_q;
        misalign_d   = misalign_q;
        if (!stall) begin
            reg_write_d  = in_RegWrite & ~misalign;
            mem_to_reg_d = in_MemToReg;
            read_data_d  = load_data;
            alu_result_d = in_aluResult;
            wb_dest_d    = in_writebackDestination;
            misalign_d   = misalign;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            read_data_q  <= 32'd0;
            alu_result_q <= 32'd0;
            wb_dest_q    <= 5'd0;
            misalign_q   <= 1'b0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            wb_dest_q    <= wb_dest_d;
            misalign_q   <= misalign_d;
        end
    end

    assign RegWrite_out             = reg_write_q;
    assign MemToReg_out             = mem_to_reg_q;
    assign readData_out             = read_data_q;
    assign aluResult_out            = alu_result_q;
    assign writebackDestination_out = wb_dest_q;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign misalign_out = misalign_q;
`else
    logic unused_misalign_q;
    assign unused_misalign_q = misalign_q;
`endif

endmodule
